// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MEM stage slice.
//   WORD_W / REG_ADDR_W : datapath word width and register-file index width
//   branch_type_t       : branch/jump kind carried down the pipeline
//   mem_state_t         : data-memory handshake FSM state
//   em_payload_t        : the E->M pipeline register contents
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_J    = 4'd3,
        BR_JAL  = 4'd4
    } branch_type_t;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

    // Only the fields that are consumed after the register are kept;
    // mem_access is used at capture time to launch the handshake.
    typedef struct packed {
        logic [WORD_W-1:0]     alu_out;
        logic [WORD_W-1:0]     write_data;
        logic [WORD_W-1:0]     pc_branch;
        logic [WORD_W-1:0]     jump_addr;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  branch;
        logic                  zero;
        branch_type_t          branch_type;
    } em_payload_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
// Data-memory request/response bus between the MEM stage and the data memory.
//   req_valid / req_ready : request handshake (stage -> memory)
//   req_we                : 1 = store, 0 = load
//   addr / wdata          : word-aligned byte address and store data
//   rsp_valid / rsp_rdata : response (read data or write ack)
// Modports: master = MEM stage, slave = data memory.
// -----------------------------------------------------------------------------
interface memory_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output addr,
        output wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  addr,
        input  wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/dmem_handshake_fsm.sv
// -----------------------------------------------------------------------------
// dmem_handshake_fsm
// IDLE/REQ/WAIT sequencer for one data-memory access.
//   clk, rst   : clock, synchronous active-high reset
//   start      : launch an access (sampled only in IDLE)
//   req_ready  : memory accepts the request (sampled only in REQ)
//   rsp_valid  : memory response / write ack (sampled only in WAIT)
//   req_valid  : request valid, high throughout REQ
//   stall      : an access is outstanding (state != IDLE)
//   rsp_done   : single-cycle strobe, the response is being consumed this edge
// -----------------------------------------------------------------------------
module dmem_handshake_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic stall,
    output logic rsp_done
);

    mem_state_t state_q;
    mem_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Responses arriving in IDLE or REQ (e.g. stale ones after a reset) are
    // deliberately ignored; only WAIT listens to rsp_valid.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (start) begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (rsp_valid) begin
                    rsp_done = 1'b1;
                    state_d  = MEM_IDLE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign stall = (state_q != MEM_IDLE);

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// Pipeline MEM stage: E->M register, data-memory handshake, branch/jump
// resolution and the M->W payload.
//   clk, rst           : clock, synchronous active-high reset
//   *_e inputs         : Execute-stage results and control
//   dmem (master)      : data-memory request/response bus
//   alu_out_m, read_data_m, write_reg_m, reg_write_m, mem_to_reg_m : M->W
//   stall_m            : freeze IF/ID/EX and hold this stage
//   pc_src_m/pc_target_m : fetch redirect
//   misalign_m         : misaligned access flag
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, a captured
// access whose address is not word aligned never reaches memory and is
// flagged on misalign_m with its writeback suppressed. When undefined,
// misalign_m is 0 and the low two address bits are simply dropped.
// -----------------------------------------------------------------------------
module memory_access_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [WORD_W-1:0]     alu_out_e,
    input  logic [WORD_W-1:0]     write_data_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic                  reg_write_e,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_write_e,
    input  logic                  mem_access_e,
    input  logic                  branch_e,
    input  logic                  zero_e,
    input  logic [WORD_W-1:0]     pc_branch_e,
    input  logic [WORD_W-1:0]     jump_addr_e,
    input  branch_type_t          branch_type_e,

    memory_access_stage_if.master dmem,

    output logic [WORD_W-1:0]     alu_out_m,
    output logic [WORD_W-1:0]     read_data_m,
    output logic [REG_ADDR_W-1:0] write_reg_m,
    output logic                  reg_write_m,
    output logic                  mem_to_reg_m,
    output logic                  stall_m,
    output logic                  pc_src_m,
    output logic [WORD_W-1:0]     pc_target_m,
    output logic                  misalign_m
);

    em_payload_t         em_q;
    em_payload_t         em_d;
    logic [WORD_W-1:0]   read_data_q;
    logic [WORD_W-1:0]   read_data_d;
    logic                start_access;
    logic                rsp_done;
    logic                br_cond;

    // ------------------------------------------------------------------
    // E->M register: loads whenever the stage is not stalled; while a
    // memory access is outstanding the E inputs are ignored.
    // ------------------------------------------------------------------
    always_comb begin
        em_d = em_q;
        if (!stall_m) begin
            em_d.alu_out     = alu_out_e;
            em_d.write_data  = write_data_e;
            em_d.pc_branch   = pc_branch_e;
            em_d.jump_addr   = jump_addr_e;
            em_d.write_reg   = write_reg_e;
            em_d.reg_write   = reg_write_e;
            em_d.mem_to_reg  = mem_to_reg_e;
            em_d.mem_write   = mem_write_e;
            em_d.branch      = branch_e;
            em_d.zero        = zero_e;
            em_d.branch_type = branch_type_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misalign_d;
    logic addr_misaligned_e;

    assign addr_misaligned_e = (alu_out_e[1:0] != 2'b00);

    always_comb begin
        misalign_d = misalign_q;
        if (!stall_m) begin
            misalign_d = mem_access_e & addr_misaligned_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    // A misaligned access is trapped here and never launches the FSM.
    assign start_access = !stall_m && mem_access_e && !addr_misaligned_e;
    assign misalign_m   = misalign_q;
    assign reg_write_m  = em_q.reg_write & ~stall_m & ~misalign_q;
    assign dmem.addr    = ADDR_W'(em_q.alu_out);
`else
    assign start_access = !stall_m && mem_access_e;
    assign misalign_m   = 1'b0;
    assign reg_write_m  = em_q.reg_write & ~stall_m;
    assign dmem.addr    = ADDR_W'({em_q.alu_out[WORD_W-1:2], 2'b00});
`endif

    // ------------------------------------------------------------------
    // Data-memory handshake
    // ------------------------------------------------------------------
    dmem_handshake_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (start_access),
        .req_ready (dmem.req_ready),
        .rsp_valid (dmem.rsp_valid),
        .req_valid (dmem.req_valid),
        .stall     (stall_m),
        .rsp_done  (rsp_done)
    );

    // Request fields come straight from the held E->M register, so they are
    // stable for as long as the request waits for ready.
    assign dmem.req_we = em_q.mem_write;
    assign dmem.wdata  = DATA_W'(em_q.write_data);

    // Load data is captured on the response edge; a store's response is just
    // a write ack and leaves the previous load data in place.
    always_comb begin
        read_data_d = read_data_q;
        if (rsp_done && !em_q.mem_write) begin
            read_data_d = WORD_W'(dmem.rsp_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    // ------------------------------------------------------------------
    // M->W payload
    // ------------------------------------------------------------------
    assign alu_out_m    = em_q.alu_out;
    assign read_data_m  = read_data_q;
    assign write_reg_m  = em_q.write_reg;
    assign mem_to_reg_m = em_q.mem_to_reg;

    // ------------------------------------------------------------------
    // Branch / jump resolution from the registered zero flag
    // ------------------------------------------------------------------
    always_comb begin
        br_cond     = 1'b0;
        pc_target_m = em_q.pc_branch;
        case (em_q.branch_type)
            BR_BEQ: begin
                br_cond = em_q.zero;
            end
            BR_BNE: begin
                br_cond = ~em_q.zero;
            end
            BR_J, BR_JAL: begin
                br_cond     = 1'b1;
                pc_target_m = em_q.jump_addr;
            end
            default: begin
                br_cond = 1'b0;
            end
        endcase
    end

    assign pc_src_m = em_q.branch & br_cond;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
// Directed test of the MEM stage: load, stalled store, ALU pass-through,
// branch decode, reset during an outstanding access and address alignment.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;
    import mips_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WORD_W-1:0]     alu_out_e;
    logic [WORD_W-1:0]     write_data_e;
    logic [REG_ADDR_W-1:0] write_reg_e;
    logic                  reg_write_e;
    logic                  mem_to_reg_e;
    logic                  mem_write_e;
    logic                  mem_access_e;
    logic                  branch_e;
    logic                  zero_e;
    logic [WORD_W-1:0]     pc_branch_e;
    logic [WORD_W-1:0]     jump_addr_e;
    branch_type_t          branch_type_e;

    logic [WORD_W-1:0]     alu_out_m;
    logic [WORD_W-1:0]     read_data_m;
    logic [REG_ADDR_W-1:0] write_reg_m;
    logic                  reg_write_m;
    logic                  mem_to_reg_m;
    logic                  stall_m;
    logic                  pc_src_m;
    logic [WORD_W-1:0]     pc_target_m;
    logic                  misalign_m;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int beats0;

    memory_access_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem_if ();

    memory_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out_e     (alu_out_e),
        .write_data_e  (write_data_e),
        .write_reg_e   (write_reg_e),
        .reg_write_e   (reg_write_e),
        .mem_to_reg_e  (mem_to_reg_e),
        .mem_write_e   (mem_write_e),
        .mem_access_e  (mem_access_e),
        .branch_e      (branch_e),
        .zero_e        (zero_e),
        .pc_branch_e   (pc_branch_e),
        .jump_addr_e   (jump_addr_e),
        .branch_type_e (branch_type_e),
        .dmem          (dmem_if),
        .alu_out_m     (alu_out_m),
        .read_data_m   (read_data_m),
        .write_reg_m   (write_reg_m),
        .reg_write_m   (reg_write_m),
        .mem_to_reg_m  (mem_to_reg_m),
        .stall_m       (stall_m),
        .pc_src_m      (pc_src_m),
        .pc_target_m   (pc_target_m),
        .misalign_m    (misalign_m)
    );

    always #5 clk = ~clk;

    // Count accepted request beats as seen on the bus.
    always @(posedge clk) begin
        if (dmem_if.req_valid && dmem_if.req_ready) begin
            beats <= beats + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input logic rw, input logic m2r,
                           input logic mw, input logic ma, input logic br,
                           input logic z, input logic [31:0] pcb,
                           input logic [31:0] ja, input branch_type_t bt);
        alu_out_e     = alu;
        write_data_e  = wd;
        write_reg_e   = wr;
        reg_write_e   = rw;
        mem_to_reg_e  = m2r;
        mem_write_e   = mw;
        mem_access_e  = ma;
        branch_e      = br;
        zero_e        = z;
        pc_branch_e   = pcb;
        jump_addr_e   = ja;
        branch_type_e = bt;
    endtask

    task automatic nop_e();
        drive_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
    endtask

    // One branch instruction through the stage, then check the redirect.
    task automatic br_case(input string tag, input branch_type_t bt, input logic z,
                           input logic exp_src, input logic [31:0] exp_tgt);
        drive_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z,
                32'h0000_0200, 32'h0000_3000, bt);
        tick();
        $display("txn: branch %s type=%0d zero=%0b pc_src=%0b target=0x%08h",
                 tag, bt, z, pc_src_m, pc_target_m);
        check({tag, "_pc_src"}, {31'd0, pc_src_m}, {31'd0, exp_src});
        if (exp_src) begin
            check({tag, "_target"}, pc_target_m, exp_tgt);
        end
    endtask

    logic [31:0] alu_vals [3];

    initial begin
        alu_vals[0] = 32'h0000_0011;
        alu_vals[1] = 32'hA5A5_0022;
        alu_vals[2] = 32'hFFFF_FFF3;

        rst = 1'b1;
        nop_e();
        dmem_if.req_ready = 1'b0;
        dmem_if.rsp_valid = 1'b0;
        dmem_if.rsp_rdata = 32'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        $display("txn: reset");
        check("rst_stall",     {31'd0, stall_m}, 32'd0);
        check("rst_req_valid", {31'd0, dmem_if.req_valid}, 32'd0);
        check("rst_pc_src",    {31'd0, pc_src_m}, 32'd0);
        check("rst_alu_out",   alu_out_m, 32'd0);
        check("rst_read_data", read_data_m, 32'd0);
        check("rst_reg_write", {31'd0, reg_write_m}, 32'd0);
        check("rst_misalign",  {31'd0, misalign_m}, 32'd0);
        rst = 1'b0;

        // ---------------- load, ready=1, response next cycle ----------------
        drive_e(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
        dmem_if.req_ready = 1'b1;
        beats0 = beats;
        tick();  // capture edge
        check("ld_req_valid", {31'd0, dmem_if.req_valid}, 32'd1);
        check("ld_addr",      dmem_if.addr, 32'h0000_0100);
        check("ld_we",        {31'd0, dmem_if.req_we}, 32'd0);
        check("ld_stall_1",   {31'd0, stall_m}, 32'd1);
        check("ld_rw_bubble", {31'd0, reg_write_m}, 32'd0);
        // Must be ignored while stalled.
        drive_e(32'h0000_0999, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
        tick();  // request accepted
        check("ld_stall_2",    {31'd0, stall_m}, 32'd1);
        check("ld_valid_drop", {31'd0, dmem_if.req_valid}, 32'd0);
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rsp_rdata = 32'hDEAD_BEEF;
        tick();  // response edge
        dmem_if.rsp_valid = 1'b0;
        dmem_if.req_ready = 1'b0;
        $display("txn: load addr=0x100 data=0x%08h", read_data_m);
        check("ld_stall_done", {31'd0, stall_m}, 32'd0);
        check("ld_read_data",  read_data_m, 32'hDEAD_BEEF);
        check("ld_mem_to_reg", {31'd0, mem_to_reg_m}, 32'd1);
        check("ld_reg_write",  {31'd0, reg_write_m}, 32'd1);
        check("ld_write_reg",  {27'd0, write_reg_m}, 32'd3);
        check("ld_alu_held",   alu_out_m, 32'h0000_0100);
        check("ld_beats",      beats - beats0, 32'd1);

        // ---------------- store, ready low for 3 cycles ----------------
        drive_e(32'h0000_0040, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
        beats0 = beats;
        tick();  // capture edge
        nop_e();
        for (int i = 0; i < 3; i++) begin
            check("st_valid", {31'd0, dmem_if.req_valid}, 32'd1);
            check("st_addr",  dmem_if.addr, 32'h0000_0040);
            check("st_wdata", dmem_if.wdata, 32'h1234_5678);
            check("st_we",    {31'd0, dmem_if.req_we}, 32'd1);
            check("st_stall", {31'd0, stall_m}, 32'd1);
            tick();
        end
        dmem_if.req_ready = 1'b1;
        check("st_valid_last", {31'd0, dmem_if.req_valid}, 32'd1);
        tick();  // accepted
        dmem_if.req_ready = 1'b0;
        check("st_valid_drop", {31'd0, dmem_if.req_valid}, 32'd0);
        check("st_stall_wait", {31'd0, stall_m}, 32'd1);
        check("st_beats",      beats - beats0, 32'd1);
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rsp_rdata = 32'h5555_5555;
        tick();  // write ack
        dmem_if.rsp_valid = 1'b0;
        $display("txn: store addr=0x40 data=0x12345678 stall=%0b", stall_m);
        check("st_stall_done", {31'd0, stall_m}, 32'd0);
        check("st_rdata_kept", read_data_m, 32'hDEAD_BEEF);
        check("st_reg_write",  {31'd0, reg_write_m}, 32'd0);

        // ---------------- back-to-back ALU ops ----------------
        for (int i = 0; i < 3; i++) begin
            drive_e(alu_vals[i], 32'h0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
            tick();
            $display("txn: alu op %0d result=0x%08h", i, alu_out_m);
            check("alu_out",   alu_out_m, alu_vals[i]);
            check("alu_stall", {31'd0, stall_m}, 32'd0);
            check("alu_rw",    {31'd0, reg_write_m}, 32'd1);
            check("alu_wreg",  {27'd0, write_reg_m}, 32'(i + 1));
        end

        // ---------------- branch decode ----------------
        br_case("beq_taken",   BR_BEQ,  1'b1, 1'b1, 32'h0000_0200);
        br_case("beq_nottkn",  BR_BEQ,  1'b0, 1'b0, 32'h0);
        br_case("bne_nottkn",  BR_BNE,  1'b1, 1'b0, 32'h0);
        br_case("bne_taken",   BR_BNE,  1'b0, 1'b1, 32'h0000_0200);
        br_case("j",           BR_J,    1'b0, 1'b1, 32'h0000_3000);
        br_case("jal",         BR_JAL,  1'b1, 1'b1, 32'h0000_3000);
        br_case("br_none",     BR_NONE, 1'b1, 1'b0, 32'h0);
        nop_e();
        tick();
        check("nop_pc_src", {31'd0, pc_src_m}, 32'd0);

        // ---------------- reset while in WAIT ----------------
        drive_e(32'h0000_0080, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
        dmem_if.req_ready = 1'b1;
        tick();  // REQ
        nop_e();
        tick();  // WAIT
        dmem_if.req_ready = 1'b0;
        check("rw_stall_wait", {31'd0, stall_m}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_stall_rst", {31'd0, stall_m}, 32'd0);
        check("rw_valid_rst", {31'd0, dmem_if.req_valid}, 32'd0);
        check("rw_rdata_rst", read_data_m, 32'd0);
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rsp_rdata = 32'h0BAD_C0DE;
        tick();  // late response, must be ignored
        dmem_if.rsp_valid = 1'b0;
        $display("txn: reset in WAIT, late rsp read_data=0x%08h", read_data_m);
        check("rw_rdata_late", read_data_m, 32'd0);
        check("rw_stall_late", {31'd0, stall_m}, 32'd0);
        check("rw_valid_late", {31'd0, dmem_if.req_valid}, 32'd0);

        // ---------------- unaligned load at 0x102 ----------------
        drive_e(32'h0000_0102, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, BR_NONE);
        dmem_if.req_ready = 1'b1;
        beats0 = beats;
        tick();
        nop_e();
`ifdef MEM_MISALIGN_TRAP_EN
        $display("txn: misaligned load 0x102 trapped misalign=%0b", misalign_m);
        check("ma_valid",     {31'd0, dmem_if.req_valid}, 32'd0);
        check("ma_flag",      {31'd0, misalign_m}, 32'd1);
        check("ma_reg_write", {31'd0, reg_write_m}, 32'd0);
        check("ma_stall",     {31'd0, stall_m}, 32'd0);
        tick();
        check("ma_beats",     beats - beats0, 32'd0);
        check("ma_flag_next", {31'd0, misalign_m}, 32'd0);
`else
        check("ma_addr_clr",  dmem_if.addr, 32'h0000_0100);
        check("ma_flag_off",  {31'd0, misalign_m}, 32'd0);
        check("ma_valid",     {31'd0, dmem_if.req_valid}, 32'd1);
        tick();  // accepted
        dmem_if.req_ready = 1'b0;
        dmem_if.rsp_valid = 1'b1;
        dmem_if.rsp_rdata = 32'hCAFE_F00D;
        tick();
        dmem_if.rsp_valid = 1'b0;
        $display("txn: load 0x102 (aligned to 0x100) data=0x%08h", read_data_m);
        check("ma_read_data", read_data_m, 32'hCAFE_F00D);
        check("ma_stall",     {31'd0, stall_m}, 32'd0);
        check("ma_beats",     beats - beats0, 32'd1);
`endif
        dmem_if.req_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
